wb_sram_slave: RTL and testbench
================================

Name: wb_sram_slave

Overview:
- Wishbone B3 classic single-access slave (responder) wrapping an on-chip synchronous word RAM.
- Hangs off one slave port of the Wishbone interconnect and services the CPU's instruction and data bus masters.
- Supports byte-lane writes, programmable wait states, error response for out-of-window addresses and master abort.

Parameters:
- ADDR_WIDTH, 10, word-address bits; RAM depth = 2**ADDR_WIDTH words of 32 bits (4 KB default).
- WAIT_STATES, 1, extra cycles inserted before the response; legal range 0..15.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset.
- wb_cyc_i  input  1  bus cycle valid.
- wb_stb_i  input  1  strobe; access requested when cyc and stb are both 1.
- wb_we_i  input  1  1 = write, 0 = read.
- wb_addr_i  input  32  byte address from the interconnect; bits [31:28] are the slave select and are ignored here.
- wb_sel_i  input  4  byte enables; bit n covers data bits [8n+7:8n].
- wb_data_i  input  32  write data.
- wb_data_o  output  32  read data.
- wb_ack_o  output  1  normal termination.
- wb_err_o  output  1  error termination.

Behaviour:
- Reset (rst = 0 at a clock edge):
  - Outputs: wb_ack_o = 0, wb_err_o = 0, wb_data_o = 0.
  - FSM goes to IDLE and the wait counter clears.
  - Any pending write is discarded.
  - RAM contents are not cleared.
  - Reset asserted mid-access aborts the access with no termination.
- Word index = wb_addr_i[ADDR_WIDTH+1:2]. wb_addr_i[1:0] is ignored.
- Out-of-window: wb_addr_i[27:ADDR_WIDTH+2] != 0 → err response instead of ack.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if cyc & stb are sampled 1, latch we, sel, data, index and the out-of-window flag. Go to WAIT if WAIT_STATES > 0, otherwise RESP. Load the counter with WAIT_STATES-1.
  - WAIT: if cyc or stb is sampled 0, abort to IDLE (no write, no response). If the counter is 0, go to RESP; otherwise decrement the counter.
  - RESP: exactly one of ack/err is 1 for exactly one cycle. Then go to IDLE unconditionally.
- Latency:
  - Request first sampled at edge E. ack/err is high during the cycle after edge E + WAIT_STATES + 1.
  - WAIT_STATES = 0: response in the cycle immediately following the request edge.
- Back-to-back: RESP always returns to IDLE, so consecutive accesses are separated by at least one idle cycle. A stb still high in the IDLE cycle after RESP is treated as a new request.
- ack/err, and wb_data_o in the response cycle, are registered outputs: they change only on clock edges.
- Write:
  - RAM bytes are updated on the edge that enters RESP, only for lanes with the latched sel bit = 1.
  - sel = 0000 still acks and changes nothing.
  - No write occurs for an err response or an aborted access.
- Read:
  - The RAM is read synchronously with the latched index so that data is valid in the RESP cycle.
  - wb_data_o = the full 32-bit word regardless of sel during an ack cycle; 0 in every other cycle, including err.
- Read-after-write: a read following a write to the same word returns the written data (the write commits before the read is issued).
- Interconnect deasserting cyc during the RESP cycle: the response still completes; no state corruption.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 0x0000_0010 with sel = 1111, then read it back (WAIT_STATES = 1) → each ack is 1 exactly 2 cycles after the request edge; read data = 0xDEADBEEF; data_o = 0 outside the ack cycle.
- Byte lanes: write 0x11223344 to word 0x4, then write 0xAABBCCDD with sel = 0101, then read → 0x11BB33DD.
- Out-of-window: ADDR_WIDTH = 10, read addr 0x0000_1000 → err pulse for 1 cycle with ack latency, ack = 0, data_o = 0. A write to the same address leaves all words unchanged.
- Abort: start a write, drop stb in the WAIT state (WAIT_STATES = 3) → no ack/err. A following read of that word returns the previous contents.
- Back-to-back with WAIT_STATES = 0: hold cyc/stb high over 4 reads of words 0..3 → acks on alternate cycles, 4 acks total, correct data each time.
- Mid-access reset: assert rst = 0 during WAIT of a write → outputs 0 next cycle, no write committed. The next access after rst = 1 completes normally.

Source files
------------

// File: rtl/wb_sram_slave.sv
// wb_sram_slave: Wishbone B3 classic slave over a byte-writable word RAM with wait states and error response.
module wb_sram_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_addr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_data_i,
  output logic [31:0] wb_data_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [3:0] WS_M1 = WAIT_STATES == 0 ? 4'd0 : 4'(WAIT_STATES - 1);
  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic req, enter;
  logic we_q, oow_q, we_c, oow_c;
  logic [3:0] sel_q, sel_c;
  logic [31:0] dat_q, dat_c;
  logic [ADDR_WIDTH-1:0] idx_q, idx_c;
  logic [31:0] mem [2**ADDR_WIDTH];
  assign req = wb_cyc_i & wb_stb_i;
  // with zero wait states the response edge is the request edge, so use live inputs while idle
  assign we_c  = state == IDLE ? wb_we_i : we_q;
  assign oow_c = state == IDLE ? wb_addr_i[27:ADDR_WIDTH+2] != '0 : oow_q;
  assign sel_c = state == IDLE ? wb_sel_i : sel_q;
  assign dat_c = state == IDLE ? wb_data_i : dat_q;
  assign idx_c = state == IDLE ? wb_addr_i[ADDR_WIDTH+1:2] : idx_q;
  assign enter = state_nxt == RESP;
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == IDLE && req) begin
      state_nxt = WAIT_STATES == 0 ? RESP : WAIT;
      cnt_nxt   = WS_M1;
    end else if (state == WAIT) begin
      state_nxt = !req ? IDLE : cnt == 4'd0 ? RESP : WAIT;
      cnt_nxt   = req && cnt != 4'd0 ? cnt - 4'd1 : cnt;
    end else if (state == RESP) begin
      state_nxt = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wb_ack_o  <= 1'b0;
      wb_err_o  <= 1'b0;
      wb_data_o <= '0;
      we_q      <= 1'b0;
      oow_q     <= 1'b0;
      sel_q     <= '0;
      dat_q     <= '0;
      idx_q     <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      wb_ack_o  <= enter && !oow_c;
      wb_err_o  <= enter && oow_c;
      wb_data_o <= enter && !oow_c && !we_c ? mem[idx_c] : '0;
      if (state == IDLE && req) begin
        we_q  <= wb_we_i;
        oow_q <= wb_addr_i[27:ADDR_WIDTH+2] != '0;
        sel_q <= wb_sel_i;
        dat_q <= wb_data_i;
        idx_q <= wb_addr_i[ADDR_WIDTH+1:2];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst && enter && we_c && !oow_c)
      for (int i = 0; i < 4; i++)
        if (sel_c[i]) mem[idx_c][8*i +: 8] <= dat_c[8*i +: 8];
  end
endmodule

// File: tb/tb_wb_sram_slave.sv
// tb_wb_sram_slave: directed checks of three slaves with 1, 3 and 0 wait states.
module tb_wb_sram_slave;
  logic clk = 0, rst = 0, stb = 0, we = 0;
  logic [2:0] cyc = '0;
  logic [31:0] addr = '0, wdat = '0;
  logic [3:0] sel = '0;
  logic [2:0] ack, err;
  logic [2:0][31:0] dout;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int WS = g == 0 ? 1 : g == 1 ? 3 : 0;
    wb_sram_slave #(.ADDR_WIDTH(10), .WAIT_STATES(WS)) dut (
      .clk(clk), .rst(rst), .wb_cyc_i(cyc[g]), .wb_stb_i(stb), .wb_we_i(we),
      .wb_addr_i(addr), .wb_sel_i(sel), .wb_data_i(wdat),
      .wb_data_o(dout[g]), .wb_ack_o(ack[g]), .wb_err_o(err[g]));
  end
  task automatic check(string tag, logic [33:0] got, logic [33:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got ack/err/data %b/%b/%h, expected %b/%b/%h", tag, got[33], got[32], got[31:0], exp[33], exp[32], exp[31:0]);
    end
  endtask
  function automatic logic [33:0] obs(int k, logic mask_data);
    return {ack[k], err[k], mask_data ? 32'h0 : dout[k]};
  endfunction
  task automatic access(int k, int ws, logic w, logic [31:0] a, logic [3:0] s, logic [31:0] d,
                        logic e, logic [31:0] exp_dat, string tag);
    @(negedge clk);
    cyc[k] = 1; stb = 1; we = w; addr = a; sel = s; wdat = d;
    @(posedge clk);
    for (int j = 0; j <= ws; j++) begin
      @(negedge clk);
      if (j < ws) check({tag, "_wait"}, obs(k, 0), 34'h0);
      else check(tag, obs(k, w), {~e, e, w ? 32'h0 : exp_dat});
    end
    cyc[k] = 0; stb = 0;
    @(negedge clk);
    check({tag, "_post"}, obs(k, 0), 34'h0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) check($sformatf("reset%0d", k), obs(k, 0), 34'h0);
    rst = 1;
    access(0, 1, 1, 32'h0000_0010, 4'hF, 32'hDEADBEEF, 0, 0, "wr_beef");
    access(0, 1, 0, 32'h0000_0010, 4'h0, 0, 0, 32'hDEADBEEF, "rd_beef");
    access(0, 1, 1, 32'h0000_0010, 4'hF, 32'h11223344, 0, 0, "wr_full");
    access(0, 1, 1, 32'h0000_0010, 4'b0101, 32'hAABBCCDD, 0, 0, "wr_lanes");
    access(0, 1, 0, 32'h0000_0010, 4'hF, 0, 0, 32'h11BB33DD, "rd_lanes");
    access(0, 1, 0, 32'h0000_0013, 4'h0, 0, 0, 32'h11BB33DD, "rd_lowbits");
    access(0, 1, 0, 32'hF000_0010, 4'hF, 0, 0, 32'h11BB33DD, "rd_slavesel");
    access(0, 1, 1, 32'h0000_0000, 4'hF, 32'h0BADF00D, 0, 0, "wr_w0");
    access(0, 1, 1, 32'h0000_0000, 4'h0, 32'hFFFFFFFF, 0, 0, "wr_sel0");
    access(0, 1, 0, 32'h0000_1000, 4'hF, 0, 1, 0, "rd_oow");
    access(0, 1, 1, 32'h0000_1000, 4'hF, 32'hFFFFFFFF, 1, 0, "wr_oow");
    access(0, 1, 0, 32'h0000_0000, 4'hF, 0, 0, 32'h0BADF00D, "rd_w0");
    access(0, 1, 0, 32'h0000_1010, 4'hF, 0, 1, 0, "rd_oow_w4");
    access(0, 1, 0, 32'h0000_0010, 4'hF, 0, 0, 32'h11BB33DD, "rd_w4_after");
    access(1, 3, 1, 32'h0000_0020, 4'hF, 32'h12345678, 0, 0, "wr_w8");
    @(negedge clk);
    cyc[1] = 1; stb = 1; we = 1; addr = 32'h20; sel = 4'hF; wdat = 32'hFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    check("abort_wait", obs(1, 0), 34'h0);
    stb = 0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      check("abort_quiet", obs(1, 0), 34'h0);
    end
    cyc[1] = 0;
    access(1, 3, 0, 32'h0000_0020, 4'hF, 0, 0, 32'h12345678, "rd_after_abort");
    for (int i = 0; i < 4; i++)
      access(2, 0, 1, 32'(i * 4), 4'hF, 32'hA0A0_0000 + 32'(i), 0, 0, "wr_b2b");
    @(negedge clk);
    cyc[2] = 1; stb = 1; we = 0; addr = 32'h0; sel = 4'hF;
    begin
      int acks = 0;
      for (int n = 0; n < 8; n++) begin
        @(negedge clk);
        acks += int'(ack[2]);
        if (n % 2 == 0) begin
          check($sformatf("b2b_rd%0d", n / 2), obs(2, 0), {2'b10, 32'hA0A0_0000 + 32'(n / 2)});
          addr = 32'((n / 2 + 1) * 4);
        end else check("b2b_gap", obs(2, 0), 34'h0);
      end
      check("b2b_ack_count", 34'(acks), 34'd4);
    end
    cyc[2] = 0; stb = 0;
    @(negedge clk);
    cyc[1] = 1; stb = 1; we = 1; addr = 32'h20; sel = 4'hF; wdat = 32'hCAFEF00D;
    @(posedge clk);
    @(negedge clk);
    rst = 0; cyc[1] = 0; stb = 0;
    @(negedge clk);
    check("midrst_out", obs(1, 0), 34'h0);
    rst = 1;
    access(1, 3, 0, 32'h0000_0020, 4'hF, 0, 0, 32'h12345678, "rd_after_rst");
    access(0, 1, 0, 32'h0000_0010, 4'hF, 0, 0, 32'h11BB33DD, "ram_kept");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
